// File: rtl/seg7_scan_reader.sv
// Samples a multiplexed 7-segment display bus, debounces each digit over a stable
// run and assembles four BCD digits into a word handed off with valid/ready.
module seg7_scan_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_sel,
  input  logic        out_ready,
  output logic [15:0] bcd_word,
  output logic        word_valid,
  output logic        word_err,
  output logic        overrun,
  output logic [3:0]  digit_mask
);

  localparam int unsigned CW = 4;
  localparam int unsigned SW = 11;

  typedef enum logic {COLLECT, PRESENT} state_t;

  state_t        state, state_next;
  logic [SW-1:0] sample_c, prev;
  logic [CW-1:0] cnt, cnt_next;
  logic          onehot_c, capture_c, transfer_c;
  logic [1:0]    pos_c;
  logic [4:0]    dec_c;
  logic [15:0]   word_next;
  logic          valid_next, err_next, ovr_next;
  logic [3:0]    mask_next;

  // Returns {pattern_ok, digit}; invalid patterns map to 4'hF.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1111110: decode = 5'h10;
      7'b0110000: decode = 5'h11;
      7'b1101101: decode = 5'h12;
      7'b1111001: decode = 5'h13;
      7'b0110011: decode = 5'h14;
      7'b1011011: decode = 5'h15;
      7'b0011111,
      7'b1011111: decode = 5'h16;
      7'b1110000: decode = 5'h17;
      7'b1111111: decode = 5'h18;
      7'b1111011,
      7'b1110011: decode = 5'h19;
      default:    decode = 5'h0F;
    endcase
  endfunction

  assign sample_c   = {seg, dig_sel};
  assign onehot_c   = (dig_sel != 4'b0000) && ((dig_sel & (dig_sel - 4'd1)) == 4'b0000);
  assign capture_c  = (sample_c == prev) && (cnt == CW'(STABLE_CYCLES - 1)) &&
                      onehot_c && (seg != 7'b0000000);
  assign transfer_c = word_valid && out_ready;
  assign dec_c      = decode(seg);

  // Run-length counter: restarts on any change, saturates at the stable length.
  always_comb begin
    cnt_next = cnt;
    if (sample_c != prev)
      cnt_next = CW'(1);
    else if (cnt < CW'(STABLE_CYCLES))
      cnt_next = cnt + CW'(1);
  end

  always_comb begin
    pos_c = 2'd0;
    case (dig_sel)
      4'b0010: pos_c = 2'd1;
      4'b0100: pos_c = 2'd2;
      4'b1000: pos_c = 2'd3;
      default: pos_c = 2'd0;
    endcase
  end

  always_comb begin
    state_next = state;
    word_next  = bcd_word;
    valid_next = word_valid;
    err_next   = word_err;
    ovr_next   = overrun;
    mask_next  = digit_mask;
    case (state)
      COLLECT: begin
        if (capture_c) begin
          word_next[{pos_c, 2'b00} +: 4] = dec_c[3:0];
          mask_next = digit_mask | (4'b0001 << pos_c);
          err_next  = word_err | ~dec_c[4];
          if (mask_next == 4'b1111) begin
            state_next = PRESENT;
            valid_next = 1'b1;
          end
        end
      end
      PRESENT: begin
        // Transfer clears the pending flags even if a capture lands on the same edge.
        if (transfer_c) begin
          state_next = COLLECT;
          valid_next = 1'b0;
          mask_next  = 4'b0000;
          err_next   = 1'b0;
          ovr_next   = 1'b0;
        end else if (capture_c) begin
          ovr_next = 1'b1;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COLLECT;
      prev       <= '0;
      cnt        <= '0;
      bcd_word   <= 16'h0000;
      word_valid <= 1'b0;
      word_err   <= 1'b0;
      overrun    <= 1'b0;
      digit_mask <= 4'b0000;
    end else begin
      state      <= state_next;
      prev       <= sample_c;
      cnt        <= cnt_next;
      bcd_word   <= word_next;
      word_valid <= valid_next;
      word_err   <= err_next;
      overrun    <= ovr_next;
      digit_mask <= mask_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: directed phase table, hand-written corner sequences
// and randomized runs, all checked every cycle against a history-based model.
module tb_seg7_scan_reader;

  localparam int unsigned S = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic        out_ready;
  logic [15:0] bcd_word;
  logic        word_valid, word_err, overrun;
  logic [3:0]  digit_mask;

  int vectors = 0;
  int errors  = 0;

  seg7_scan_reader #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .seg(seg), .dig_sel(dig_sel), .out_ready(out_ready),
    .bcd_word(bcd_word), .word_valid(word_valid), .word_err(word_err),
    .overrun(overrun), .digit_mask(digit_mask)
  );

  always #5 clk = ~clk;

  // Reference model: capture when the last S samples since reset agree and the run began exactly S samples ago.
  logic [10:0] hist[$];
  int          total;
  logic [3:0]  m_nib[4];
  logic [3:0]  m_mask;
  logic        m_err, m_ovr, m_valid;

  function automatic int seg_value(input logic [6:0] s);
    case (s)
      7'b1111110: return 0;
      7'b0110000: return 1;
      7'b1101101: return 2;
      7'b1111001: return 3;
      7'b0110011: return 4;
      7'b1011011: return 5;
      7'b0011111, 7'b1011111: return 6;
      7'b1110000: return 7;
      7'b1111111: return 8;
      7'b1111011, 7'b1110011: return 9;
      default: return -1;
    endcase
  endfunction

  function automatic logic [15:0] m_word();
    return {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
  endfunction

  task automatic model_edge(input logic r, input logic [6:0] s, input logic [3:0] d, input logic rd);
    logic [10:0] cur;
    bit          cap;
    int          pos, v;
    cur = {s, d};
    if (r) begin
      hist.delete();
      total = 0;
      foreach (m_nib[i]) m_nib[i] = 4'h0;
      m_mask = 4'h0; m_err = 1'b0; m_ovr = 1'b0; m_valid = 1'b0;
      return;
    end
    hist.push_back(cur);
    total++;
    if (hist.size() > S + 1) void'(hist.pop_front());
    cap = (total >= S);
    for (int i = 1; i <= S; i++)
      if (cap && hist[hist.size() - i] != cur) cap = 0;
    if (cap && total > S && hist[0] == cur) cap = 0;
    if ($countones(d) != 1 || s == 7'b0) cap = 0;
    pos = 0;
    for (int i = 0; i < 4; i++) if (d[i]) pos = i;
    if (m_valid) begin
      if (rd) begin
        m_valid = 1'b0; m_mask = 4'h0; m_err = 1'b0; m_ovr = 1'b0;
      end else if (cap) m_ovr = 1'b1;
    end else if (cap) begin
      v = seg_value(s);
      m_nib[pos] = (v < 0) ? 4'hF : 4'(v);
      if (v < 0) m_err = 1'b1;
      m_mask[pos] = 1'b1;
      if (m_mask == 4'hF) m_valid = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [15:0] w, input logic vl,
                       input logic er, input logic ov, input logic [3:0] mk);
    vectors++;
    if (bcd_word !== w || word_valid !== vl || word_err !== er || overrun !== ov || digit_mask !== mk) begin
      errors++;
      $display("FAIL %s @%0t: got word=%h valid=%b err=%b ovr=%b mask=%b, expected word=%h valid=%b err=%b ovr=%b mask=%b",
               name, $time, bcd_word, word_valid, word_err, overrun, digit_mask, w, vl, er, ov, mk);
    end
  endtask

  task automatic step(input logic r, input logic [6:0] s, input logic [3:0] d, input logic rd);
    reset = r; seg = s; dig_sel = d; out_ready = rd;
    @(posedge clk);
    model_edge(r, s, d, rd);
    #1;
    check("model", m_word(), m_valid, m_err, m_ovr, m_mask);
  endtask

  typedef struct {
    logic        r;
    logic [6:0]  s;
    logic [3:0]  d;
    logic        rd;
    int          n;
    logic [15:0] w;
    logic        vl, er, ov;
    logic [3:0]  mk;
  } vec_t;

  vec_t tbl[$];

  initial begin
    reset = 1'b1; seg = '0; dig_sel = '0; out_ready = 1'b0;
    tbl = '{
      '{1'b1, 7'h00, 4'b0000, 1'b0,  2, 16'h0000, 0, 0, 0, 4'b0000},
      '{1'b0, 7'h79, 4'b1000, 1'b0,  4, 16'h3000, 0, 0, 0, 4'b1000},
      '{1'b0, 7'h33, 4'b0100, 1'b0,  4, 16'h3400, 0, 0, 0, 4'b1100},
      '{1'b0, 7'h5B, 4'b0010, 1'b0,  4, 16'h3450, 0, 0, 0, 4'b1110},
      '{1'b0, 7'h1F, 4'b0001, 1'b0,  4, 16'h3456, 1, 0, 0, 4'b1111},
      '{1'b0, 7'h1F, 4'b0001, 1'b1,  1, 16'h3456, 0, 0, 0, 4'b0000},
      '{1'b0, 7'h7F, 4'b0001, 1'b0,  3, 16'h3456, 0, 0, 0, 4'b0000},
      '{1'b0, 7'h30, 4'b0001, 1'b0,  1, 16'h3456, 0, 0, 0, 4'b0000},
      '{1'b0, 7'h7F, 4'b0001, 1'b0, 20, 16'h3458, 0, 0, 0, 4'b0001},
      '{1'b0, 7'h7F, 4'b0000, 1'b0, 10, 16'h3458, 0, 0, 0, 4'b0001},
      '{1'b0, 7'h7F, 4'b0011, 1'b0, 10, 16'h3458, 0, 0, 0, 4'b0001},
      '{1'b0, 7'h00, 4'b0100, 1'b0, 10, 16'h3458, 0, 0, 0, 4'b0001},
      '{1'b0, 7'h7E, 4'b1000, 1'b0,  4, 16'h0458, 0, 0, 0, 4'b1001},
      '{1'b0, 7'h70, 4'b0100, 1'b0,  4, 16'h0758, 0, 0, 0, 4'b1101},
      '{1'b0, 7'h49, 4'b0010, 1'b0,  4, 16'h07F8, 1, 1, 0, 4'b1111},
      '{1'b0, 7'h7B, 4'b0001, 1'b0,  4, 16'h07F8, 1, 1, 1, 4'b1111},
      '{1'b0, 7'h7B, 4'b0001, 1'b1,  1, 16'h07F8, 0, 0, 0, 4'b0000},
      '{1'b0, 7'h6D, 4'b1000, 1'b0,  4, 16'h27F8, 0, 0, 0, 4'b1000},
      '{1'b0, 7'h5F, 4'b0100, 1'b0,  4, 16'h26F8, 0, 0, 0, 4'b1100},
      '{1'b0, 7'h73, 4'b0010, 1'b0,  4, 16'h2698, 0, 0, 0, 4'b1110},
      '{1'b1, 7'h73, 4'b0010, 1'b0,  1, 16'h0000, 0, 0, 0, 4'b0000},
      '{1'b0, 7'h73, 4'b0010, 1'b0,  3, 16'h0000, 0, 0, 0, 4'b0000},
      '{1'b0, 7'h73, 4'b0010, 1'b0,  1, 16'h0090, 0, 0, 0, 4'b0010}
    };
    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) step(tbl[i].r, tbl[i].s, tbl[i].d, tbl[i].rd);
      check($sformatf("table[%0d]", i), tbl[i].w, tbl[i].vl, tbl[i].er, tbl[i].ov, tbl[i].mk);
    end

    // Capture and transfer on the same edge: clear wins, overrun stays 0.
    for (int c = 0; c < 4; c++) step(1'b0, 7'h30, 4'b1000, 1'b0);
    for (int c = 0; c < 4; c++) step(1'b0, 7'h6D, 4'b0100, 1'b0);
    for (int c = 0; c < 4; c++) step(1'b0, 7'h33, 4'b0001, 1'b0);
    check("fill_word", 16'h1294, 1'b1, 1'b0, 1'b0, 4'b1111);
    for (int c = 0; c < 3; c++) step(1'b0, 7'h7E, 4'b1000, 1'b0);
    check("pre_coincide", 16'h1294, 1'b1, 1'b0, 1'b0, 4'b1111);
    step(1'b0, 7'h7E, 4'b1000, 1'b1);
    check("coincide", 16'h1294, 1'b0, 1'b0, 1'b0, 4'b0000);
    for (int c = 0; c < 5; c++) step(1'b0, 7'h7E, 4'b1000, 1'b0);
    check("no_recapture", 16'h1294, 1'b0, 1'b0, 1'b0, 4'b0000);
    for (int c = 0; c < 4; c++) step(1'b0, 7'h7B, 4'b0001, 1'b1);
    check("nine_alt", 16'h1299, 1'b0, 1'b0, 1'b0, 4'b0001);

    // Randomized runs of mixed patterns, selects, ready and occasional reset.
    for (int k = 0; k < 600; k++) begin
      logic [6:0] pats[13];
      logic [6:0] s;
      logic [3:0] d;
      logic       r, rd;
      int         len;
      pats = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h1F, 7'h5F,
               7'h70, 7'h7F, 7'h7B, 7'h73, 7'h00};
      case ($urandom_range(9))
        0:       s = 7'($urandom);
        default: s = pats[$urandom_range(12)];
      endcase
      case ($urandom_range(7))
        0:       d = 4'($urandom);
        default: d = 4'b0001 << $urandom_range(3);
      endcase
      r   = ($urandom_range(59) == 0);
      len = $urandom_range(1, 7);
      for (int c = 0; c < len; c++) begin
        rd = ($urandom_range(3) == 0);
        step(r && c == 0, s, d, rd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
